// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side supplies operands and takes results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, LSB first,
// one full-subtractor cell and a registered borrow, one operation in flight.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             borrow_q;
    logic             ovf_q;

    logic             x;
    logic             y;
    logic             d_bit;
    logic             br_next;
    logic             last;

    // Full-subtractor cell on the current LSBs.
    assign x       = a_sr[0];
    assign y       = b_sr[0];
    assign d_bit   = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = BUSY;
            BUSY:    if (last)          state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        br    <= bus.borrow_in;
                        cnt   <= '0;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
                    end
                end
                BUSY: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
                    br      <= br_next;
                    cnt     <= cnt + 1'b1;
                    // The bit produced on the last step is the result sign.
                    if (last) begin
                        borrow_q <= br_next;
                        ovf_q    <= (a_msb != b_msb) && (d_bit != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.diff       = diff_sr;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=5 against an
// arithmetic reference model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    int   sa[$];
    int   sb[$];
    int   sbin[$];

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(5)) if5 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_subtractor #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic reference: unsigned result for diff/borrow, signed range for overflow.
    function automatic void model(input int w, input int a, input int b, input int bin,
                                  output int d, output int bo, output int ov);
        int sa_v, sb_v, r;
        d    = (a - b - bin) & ((1 << w) - 1);
        bo   = (a - b - bin < 0) ? 1 : 0;
        sa_v = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb_v = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        r    = sa_v - sb_v - bin;
        ov   = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input int a, input int b, input int bin);
        int d, bo, ov, k;
        model(8, a, b, bin, d, bo, ov);
        if8.a         = 8'(a);
        if8.b         = 8'(b);
        if8.borrow_in = 1'(bin);
        if8.out_ready = 1'b1;
        if8.in_valid  = 1'b1;
        k = 0;
        while (!if8.in_ready && k < 50) begin tick(); k++; end
        tick();
        if8.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(if8.busy), 1);
        k = 0;
        do begin tick(); k++; end while (!if8.out_valid && k < 40);
        check({tag, "_latency"}, k, 8);
        check({tag, "_diff"}, 32'(if8.diff), d);
        check({tag, "_borrow"}, 32'(if8.borrow_out), bo);
        check({tag, "_ovf"}, 32'(if8.overflow), ov);
        tick();
        check({tag, "_vld_1cyc"}, 32'(if8.out_valid), 0);
        check({tag, "_rdy_back"}, 32'(if8.in_ready), 1);
    endtask

    task automatic op5(input string tag, input int a, input int b, input int bin);
        int d, bo, ov, k;
        model(5, a, b, bin, d, bo, ov);
        if5.a         = 5'(a);
        if5.b         = 5'(b);
        if5.borrow_in = 1'(bin);
        if5.out_ready = 1'b1;
        if5.in_valid  = 1'b1;
        k = 0;
        while (!if5.in_ready && k < 50) begin tick(); k++; end
        tick();
        if5.in_valid = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!if5.out_valid && k < 40);
        check({tag, "_latency"}, k, 5);
        check({tag, "_diff"}, 32'(if5.diff), d);
        check({tag, "_borrow"}, 32'(if5.borrow_out), bo);
        check({tag, "_ovf"}, 32'(if5.overflow), ov);
        tick();
    endtask

    // Streams the operand queues with in_valid/out_ready held high; results are
    // matched in order and the spacing between accepting edges is recorded.
    task automatic stream8(input string tag);
        int exp_d[$], exp_bo[$], exp_ov[$], acc[$];
        int idx, t, pend, got, n, d, bo, ov;
        n = sa.size();
        idx = 0; t = 0; pend = 0; got = 0;
        if8.out_ready = 1'b1;
        if8.a         = 8'(sa[0]);
        if8.b         = 8'(sb[0]);
        if8.borrow_in = 1'(sbin[0]);
        if8.in_valid  = 1'b1;
        while (got < n && t < n * 12 + 50) begin
            if (pend != 0) begin
                pend = 0;
                idx++;
                if (idx < n) begin
                    if8.a         = 8'(sa[idx]);
                    if8.b         = 8'(sb[idx]);
                    if8.borrow_in = 1'(sbin[idx]);
                end else begin
                    if8.in_valid = 1'b0;
                end
            end
            if (if8.out_valid && exp_d.size() > 0) begin
                check({tag, "_diff"}, 32'(if8.diff), exp_d.pop_front());
                check({tag, "_borrow"}, 32'(if8.borrow_out), exp_bo.pop_front());
                check({tag, "_ovf"}, 32'(if8.overflow), exp_ov.pop_front());
                got++;
            end
            if (if8.in_ready && if8.in_valid) begin
                model(8, sa[idx], sb[idx], sbin[idx], d, bo, ov);
                exp_d.push_back(d);
                exp_bo.push_back(bo);
                exp_ov.push_back(ov);
                acc.push_back(t + 1);
                pend = 1;
            end
            tick();
            t++;
        end
        if8.in_valid = 1'b0;
        check({tag, "_results"}, got, n);
        for (int i = 1; i < acc.size(); i++)
            check({tag, "_accept_gap"}, acc[i] - acc[i-1], 10);
        sa.delete(); sb.delete(); sbin.delete();
    endtask

    initial begin
        int k;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.borrow_in = 1'b0; if8.out_ready = 1'b1;
        if5.in_valid = 1'b0; if5.a = '0; if5.b = '0; if5.borrow_in = 1'b0; if5.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(if8.in_ready), 1);
        check("rst_out_valid", 32'(if8.out_valid), 0);
        check("rst_busy", 32'(if8.busy), 0);
        check("rst_diff", 32'(if8.diff), 0);
        check("rst_borrow", 32'(if8.borrow_out), 0);
        check("rst_ovf", 32'(if8.overflow), 0);

        op8("basic", 8'h35, 8'h12, 0);
        op8("neg", 8'h00, 8'h01, 0);
        op8("ovf_neg", 8'h80, 8'h01, 0);
        op8("bin_eq", 8'h10, 8'h10, 1);
        op8("ovf_pos", 8'h7F, 8'hFF, 0);

        // Backpressure: result must hold and new operands must wait.
        if8.out_ready = 1'b0;
        if8.a = 8'h35; if8.b = 8'h12; if8.borrow_in = 1'b0; if8.in_valid = 1'b1;
        tick();
        if8.a = 8'h44; if8.b = 8'h11;
        k = 0;
        while (!if8.out_valid && k < 40) begin tick(); k++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(if8.out_valid), 1);
            check("bp_in_ready", 32'(if8.in_ready), 0);
            check("bp_diff_hold", 32'(if8.diff), 32'h23);
        end
        if8.out_ready = 1'b1;
        tick();
        check("bp_release_rdy", 32'(if8.in_ready), 1);
        check("bp_release_vld", 32'(if8.out_valid), 0);
        tick();
        if8.in_valid = 1'b0;
        check("bp_new_accept", 32'(if8.busy), 1);
        k = 0;
        while (!if8.out_valid && k < 40) begin tick(); k++; end
        check("bp_new_diff", 32'(if8.diff), 32'h33);
        tick();

        // Reset in the middle of an operation.
        if8.a = 8'hAA; if8.b = 8'h33; if8.borrow_in = 1'b1; if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 32'(if8.out_valid), 0);
        check("abort_in_ready", 32'(if8.in_ready), 1);
        check("abort_busy", 32'(if8.busy), 0);
        check("abort_diff", 32'(if8.diff), 0);
        check("abort_borrow", 32'(if8.borrow_out), 0);
        check("abort_ovf", 32'(if8.overflow), 0);
        op8("after_abort", 8'h05, 8'h03, 0);

        sa = '{8'h35, 8'h00, 8'h80}; sb = '{8'h12, 8'h01, 8'h01}; sbin = '{0, 0, 1};
        stream8("b2b");

        for (int i = 0; i < 40; i++) begin
            sa.push_back(int'($urandom_range(0, 255)));
            sb.push_back(int'($urandom_range(0, 255)));
            sbin.push_back(int'($urandom_range(0, 1)));
        end
        sa.push_back(8'hFF); sb.push_back(8'h00); sbin.push_back(1);
        sa.push_back(8'h80); sb.push_back(8'h7F); sbin.push_back(0);
        stream8("rand");

        op5("w5_edge", 5'h00, 5'h1F, 0);
        op5("w5_ovf", 5'h10, 5'h01, 0);
        for (int i = 0; i < 6; i++)
            op5("w5_rand", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
